// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 raster timing constants shared by the timing
// generator and the pixel-colour stage.
//   COORD_W          width of the x/y scan coordinates
//   H_*/V_*          active, porch and sync lengths (pixels / lines)
//   H_TOTAL/V_TOTAL  full line / frame lengths
//   HS_*/VS_*        first and last counter value with sync asserted
package vga_timing_pkg;
    localparam int COORD_W  = 10;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525

    localparam int HS_START = H_ACTIVE + H_FP;                  // 656
    localparam int HS_END   = HS_START + H_SYNC - 1;            // 751
    localparam int VS_START = V_ACTIVE + V_FP;                  // 490
    localparam int VS_END   = VS_START + V_SYNC - 1;            // 491

    // Asserted level of HS/VS: 0 = active-low.
    localparam bit SYNC_POL = 1'b0;
endpackage

// File: rtl/clk_en_divider.sv
// clk_en_divider: divides the system clock down to a pixel-rate enable.
//   clk, rst  system clock, async active-high reset
//   pix_en    one-clk strobe, high in the cycle where div_cnt == CLK_DIV-1
//   vga_clk   pixel clock for the DAC, high while div_cnt >= CLK_DIV/2
// Both outputs are registered from the next divider count so they are
// glitch-free and line up with the cycle whose div_cnt they describe.
module clk_en_divider #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic pix_en,
    output logic vga_clk
);
    localparam int            DW   = $clog2(CLK_DIV);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] HALF = DW'(CLK_DIV / 2);

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nxt;

    always_comb begin
        div_nxt = (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            pix_en  <= 1'b0;
            vga_clk <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            pix_en  <= (div_nxt == LAST);
            // Rises mid-pixel, falls on the edge where x/y update.
            vga_clk <= (div_nxt >= HALF);
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator for the VGA DAC path.
//   clk, rst        50 MHz system clock, async active-high reset
//   x, y            current scan column / line (unclamped, incl. blanking)
//   active_pixels   high inside the visible window
//   pix_en          one-clk strobe per pixel boundary
//   frame_start     one-clk pulse as the outputs enter (0, V_ACTIVE)
//   VGA_HS/VGA_VS   syncs, asserted level SYNC_POL
//   VGA_BLANK_N     = active_pixels
//   VGA_SYNC_N      tied low (no sync-on-green)
//   VGA_CLK         pixel clock to the DAC
// All scan outputs load together on the pix_en edge from the pre-increment
// counters, so they lag the counters by one pixel and stay mutually aligned.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP,
    parameter bit SYNC_POL = vga_timing_pkg::SYNC_POL
) (
    input  logic                               clk,
    input  logic                               rst,
    output logic [vga_timing_pkg::COORD_W-1:0] x,
    output logic [vga_timing_pkg::COORD_W-1:0] y,
    output logic                               active_pixels,
    output logic                               pix_en,
    output logic                               frame_start,
    output logic                               VGA_HS,
    output logic                               VGA_VS,
    output logic                               VGA_BLANK_N,
    output logic                               VGA_SYNC_N,
    output logic                               VGA_CLK
);
    import vga_timing_pkg::*;

    typedef logic [COORD_W-1:0] coord_t;

    localparam coord_t H_LAST = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam coord_t V_LAST = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam coord_t H_VIS  = coord_t'(H_ACTIVE);
    localparam coord_t V_VIS  = coord_t'(V_ACTIVE);
    localparam coord_t HS_BEG = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_FIN = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_BEG = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_FIN = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    coord_t h_cnt;
    coord_t v_cnt;

    clk_en_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clk     (clk),
        .rst     (rst),
        .pix_en  (pix_en),
        .vga_clk (VGA_CLK)
    );

    // Counters wrap at their last value, never exceeding H_TOTAL-1 / V_TOTAL-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x             <= '0;
            y             <= '0;
            active_pixels <= 1'b0;
            VGA_HS        <= ~SYNC_POL;
            VGA_VS        <= ~SYNC_POL;
            frame_start   <= 1'b0;
        end else begin
            // pix_en never repeats on consecutive clks, so this is one clk wide.
            frame_start <= pix_en && (h_cnt == '0) && (v_cnt == V_VIS);
            if (pix_en) begin
                x             <= h_cnt;
                y             <= v_cnt;
                active_pixels <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
                VGA_HS        <= (h_cnt >= HS_BEG && h_cnt <= HS_FIN) ? SYNC_POL : ~SYNC_POL;
                VGA_VS        <= (v_cnt >= VS_BEG && v_cnt <= VS_FIN) ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

    assign VGA_BLANK_N = active_pixels;
    assign VGA_SYNC_N  = 1'b0;
endmodule
